// File: rtl/timer_arb.sv
// Two-master arbiter in front of the timer register port (mtime/mtimecmp/msip).
// Independent write and read arbitration; read responses are routed back to the issuing port.
module timer_arb #(
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned AW        = 32
) (
    input  logic          clk,
    input  logic          resetb,

    input  logic          m0_wreq,
    input  logic [AW-1:0] m0_waddr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic          m0_wgrant,
    input  logic          m0_rreq,
    input  logic [AW-1:0] m0_raddr,
    output logic          m0_rgrant,
    output logic          m0_rresp,
    output logic [31:0]   m0_rdata,

    input  logic          m1_wreq,
    input  logic [AW-1:0] m1_waddr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic          m1_wgrant,
    input  logic          m1_rreq,
    input  logic [AW-1:0] m1_raddr,
    output logic          m1_rgrant,
    output logic          m1_rresp,
    output logic [31:0]   m1_rdata,

    output logic          t_wready,
    output logic [AW-1:0] t_waddr,
    output logic [31:0]   t_wdata,
    output logic [3:0]    t_wstrb,
    output logic          t_rready,
    output logic [AW-1:0] t_raddr,
    input  logic          t_rresp,
    input  logic [31:0]   t_rdata
);

    localparam logic ROUND_ROBIN = (PRIO_MODE == 0);

    logic w_last;
    logic r_last;
    logic r_own;
    logic r_pend;

    // Port 1 wins a tie only in round-robin mode when port 0 won last time.
    always_comb begin
        m1_wgrant = m1_wreq & (~m0_wreq | (ROUND_ROBIN & ~w_last));
        m0_wgrant = m0_wreq & ~m1_wgrant;
        m1_rgrant = m1_rreq & (~m0_rreq | (ROUND_ROBIN & ~r_last));
        m0_rgrant = m0_rreq & ~m1_rgrant;
    end

    always_comb begin
        t_wready = m0_wgrant | m1_wgrant;
        t_waddr  = m1_wgrant ? m1_waddr : m0_waddr;
        t_wdata  = m1_wgrant ? m1_wdata : m0_wdata;
        t_wstrb  = m1_wgrant ? m1_wstrb : m0_wstrb;
        t_rready = m0_rgrant | m1_rgrant;
        t_raddr  = m1_rgrant ? m1_raddr : m0_raddr;
    end

    // Responses without a matching outstanding read are dropped.
    always_comb begin
        m0_rresp = t_rresp & r_pend & ~r_own;
        m1_rresp = t_rresp & r_pend & r_own;
        m0_rdata = m0_rresp ? t_rdata : 32'h0;
        m1_rdata = m1_rresp ? t_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            w_last <= 1'b1;
            r_last <= 1'b1;
            r_own  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            if (t_wready) begin
                w_last <= m1_wgrant;
            end
            if (t_rready) begin
                r_last <= m1_rgrant;
                r_own  <= m1_rgrant;
            end
            r_pend <= t_rready;
        end
    end

endmodule

// File: tb/tb_timer_arb.sv
// Bench for timer_arb: round-robin and fixed-priority instances side by side, checked by
// a vector table, hand-written corner sequences and a random run against a reference model.
module tb_timer_arb;

    localparam int AW = 32;
    localparam logic [AW-1:0] MTIME_BASE    = 32'h0200_BFF8;
    localparam logic [AW-1:0] MTIMECMP_BASE = 32'h0200_4000;
    localparam logic [AW-1:0] MSIP_BASE     = 32'h0200_0000;

    logic          clk = 1'b0;
    logic          resetb;
    logic          m0_wreq, m1_wreq, m0_rreq, m1_rreq;
    logic [AW-1:0] m0_waddr, m1_waddr, m0_raddr, m1_raddr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_wstrb, m1_wstrb;
    logic          t_rresp;
    logic [31:0]   t_rdata;

    // Index 0: PRIO_MODE = 0 (round-robin), index 1: PRIO_MODE = 1 (fixed priority).
    logic          wg0 [2], wg1 [2], rg0 [2], rg1 [2], rr0 [2], rr1 [2];
    logic [31:0]   rd0 [2], rd1 [2], twd [2];
    logic          twr [2], trr [2];
    logic [AW-1:0] twa [2], tra [2];
    logic [3:0]    tws [2];

    int n_vec = 0;
    int n_bad = 0;

    // Reference state per instance: last winner, outstanding read owner.
    int  m_wlast [2];
    int  m_rlast [2];
    int  m_rown  [2];
    bit  m_rpend [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        timer_arb #(.PRIO_MODE(g), .AW(AW)) u_dut (
            .clk       (clk),
            .resetb    (resetb),
            .m0_wreq   (m0_wreq),
            .m0_waddr  (m0_waddr),
            .m0_wdata  (m0_wdata),
            .m0_wstrb  (m0_wstrb),
            .m0_wgrant (wg0[g]),
            .m0_rreq   (m0_rreq),
            .m0_raddr  (m0_raddr),
            .m0_rgrant (rg0[g]),
            .m0_rresp  (rr0[g]),
            .m0_rdata  (rd0[g]),
            .m1_wreq   (m1_wreq),
            .m1_waddr  (m1_waddr),
            .m1_wdata  (m1_wdata),
            .m1_wstrb  (m1_wstrb),
            .m1_wgrant (wg1[g]),
            .m1_rreq   (m1_rreq),
            .m1_raddr  (m1_raddr),
            .m1_rgrant (rg1[g]),
            .m1_rresp  (rr1[g]),
            .m1_rdata  (rd1[g]),
            .t_wready  (twr[g]),
            .t_waddr   (twa[g]),
            .t_wdata   (twd[g]),
            .t_wstrb   (tws[g]),
            .t_rready  (trr[g]),
            .t_raddr   (tra[g]),
            .t_rresp   (t_rresp),
            .t_rdata   (t_rdata)
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner of one channel: -1 none, else port number.
    function automatic int arb(input logic a, input logic b, input int last, input int prio);
        if (!a && !b) return -1;
        if (a && !b) return 0;
        if (b && !a) return 1;
        return (prio != 0) ? 0 : 1 - last;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wlast[d] = 1;
            m_rlast[d] = 1;
            m_rown[d]  = 0;
            m_rpend[d] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        m0_wreq = 0; m1_wreq = 0; m0_rreq = 0; m1_rreq = 0;
        m0_waddr = '0; m1_waddr = '0; m0_raddr = '0; m1_raddr = '0;
        m0_wdata = '0; m1_wdata = '0; m0_wstrb = '0; m1_wstrb = '0;
        t_rresp = 0; t_rdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetb = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        resetb = 1'b1;
        model_reset();
    endtask

    // Compare every output of both instances with the model, then advance the model one edge.
    task automatic model_check();
        int wg, rg, rp;
        logic [AW-1:0] ea;
        for (int d = 0; d < 2; d++) begin
            wg = arb(m0_wreq, m1_wreq, m_wlast[d], d);
            rg = arb(m0_rreq, m1_rreq, m_rlast[d], d);
            rp = (t_rresp && m_rpend[d]) ? m_rown[d] : -1;
            chk($sformatf("rand%0d m0_wgrant", d), 64'(wg0[d]), 64'(wg == 0));
            chk($sformatf("rand%0d m1_wgrant", d), 64'(wg1[d]), 64'(wg == 1));
            chk($sformatf("rand%0d t_wready", d), 64'(twr[d]), 64'(wg >= 0));
            if (wg >= 0) begin
                ea = (wg == 1) ? m1_waddr : m0_waddr;
                chk($sformatf("rand%0d t_waddr", d), 64'(twa[d]), 64'(ea));
                chk($sformatf("rand%0d t_wdata", d), 64'(twd[d]),
                    64'((wg == 1) ? m1_wdata : m0_wdata));
                chk($sformatf("rand%0d t_wstrb", d), 64'(tws[d]),
                    64'((wg == 1) ? m1_wstrb : m0_wstrb));
            end
            chk($sformatf("rand%0d m0_rgrant", d), 64'(rg0[d]), 64'(rg == 0));
            chk($sformatf("rand%0d m1_rgrant", d), 64'(rg1[d]), 64'(rg == 1));
            chk($sformatf("rand%0d t_rready", d), 64'(trr[d]), 64'(rg >= 0));
            if (rg >= 0) begin
                ea = (rg == 1) ? m1_raddr : m0_raddr;
                chk($sformatf("rand%0d t_raddr", d), 64'(tra[d]), 64'(ea));
            end
            chk($sformatf("rand%0d m0_rresp", d), 64'(rr0[d]), 64'(rp == 0));
            chk($sformatf("rand%0d m1_rresp", d), 64'(rr1[d]), 64'(rp == 1));
            chk($sformatf("rand%0d m0_rdata", d), 64'(rd0[d]), 64'((rp == 0) ? t_rdata : 32'h0));
            chk($sformatf("rand%0d m1_rdata", d), 64'(rd1[d]), 64'((rp == 1) ? t_rdata : 32'h0));
            if (wg >= 0) m_wlast[d] = wg;
            if (rg >= 0) begin
                m_rlast[d] = rg;
                m_rown[d]  = rg;
            end
            m_rpend[d] = (rg >= 0);
        end
    endtask

    typedef struct packed {
        logic       w0, w1, r0, r1;
        logic [1:0] wg;   // {m1_wgrant, m0_wgrant} expected from round-robin instance
        logic [1:0] rg;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic prev_rd;
        logic [1:0] pw, pr;

        tbl[0]  = '{w0: 1, w1: 0, r0: 0, r1: 0, wg: 2'b01, rg: 2'b00};
        tbl[1]  = '{w0: 1, w1: 1, r0: 0, r1: 0, wg: 2'b10, rg: 2'b00};
        tbl[2]  = '{w0: 1, w1: 1, r0: 0, r1: 0, wg: 2'b01, rg: 2'b00};
        tbl[3]  = '{w0: 0, w1: 1, r0: 0, r1: 0, wg: 2'b10, rg: 2'b00};
        tbl[4]  = '{w0: 1, w1: 1, r0: 1, r1: 1, wg: 2'b01, rg: 2'b01};
        tbl[5]  = '{w0: 0, w1: 0, r0: 1, r1: 1, wg: 2'b00, rg: 2'b10};
        tbl[6]  = '{w0: 1, w1: 1, r0: 0, r1: 1, wg: 2'b10, rg: 2'b10};
        tbl[7]  = '{w0: 1, w1: 1, r0: 1, r1: 1, wg: 2'b01, rg: 2'b01};
        tbl[8]  = '{w0: 0, w1: 0, r0: 0, r1: 0, wg: 2'b00, rg: 2'b00};
        tbl[9]  = '{w0: 0, w1: 1, r0: 1, r1: 0, wg: 2'b10, rg: 2'b01};
        tbl[10] = '{w0: 1, w1: 1, r0: 1, r1: 1, wg: 2'b01, rg: 2'b10};

        resetb = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d grants", d),
                64'({wg0[d], wg1[d], rg0[d], rg1[d], twr[d], trr[d]}), 64'h0);
            chk($sformatf("reset%0d rresp", d), 64'({rr0[d], rr1[d]}), 64'h0);
        end
        do_reset();

        // Grant table
        for (int i = 0; i < 11; i++) begin
            m0_wreq = tbl[i].w0; m1_wreq = tbl[i].w1;
            m0_rreq = tbl[i].r0; m1_rreq = tbl[i].r1;
            pw = tbl[i].w0 ? 2'b01 : (tbl[i].w1 ? 2'b10 : 2'b00);
            pr = tbl[i].r0 ? 2'b01 : (tbl[i].r1 ? 2'b10 : 2'b00);
            #3;
            chk($sformatf("tbl[%0d] rr wgrant", i), 64'({wg1[0], wg0[0]}), 64'(tbl[i].wg));
            chk($sformatf("tbl[%0d] rr rgrant", i), 64'({rg1[0], rg0[0]}), 64'(tbl[i].rg));
            chk($sformatf("tbl[%0d] rr t_wready", i), 64'(twr[0]), 64'(tbl[i].wg != 2'b00));
            chk($sformatf("tbl[%0d] rr t_rready", i), 64'(trr[0]), 64'(tbl[i].rg != 2'b00));
            chk($sformatf("tbl[%0d] prio wgrant", i), 64'({wg1[1], wg0[1]}), 64'(pw));
            chk($sformatf("tbl[%0d] prio rgrant", i), 64'({rg1[1], rg0[1]}), 64'(pr));
            @(posedge clk);
            #1;
        end

        // Single write to MTIMECMP from port 0
        do_reset();
        m0_wreq = 1; m0_waddr = MTIMECMP_BASE; m0_wdata = 32'h0000_0100; m0_wstrb = 4'hF;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("wr%0d m0_wgrant", d), 64'(wg0[d]), 64'h1);
            chk($sformatf("wr%0d t_wready", d), 64'(twr[d]), 64'h1);
            chk($sformatf("wr%0d t_wdata", d), 64'(twd[d]), 64'h100);
            chk($sformatf("wr%0d t_waddr", d), 64'(twa[d]), 64'(MTIMECMP_BASE));
        end
        @(posedge clk);
        #1;
        // w_last is now 0: a tie must go to port 1 in round-robin mode
        m1_wreq = 1; m1_wdata = 32'hB;
        #3;
        chk("wr w_last=0 m1_wgrant", 64'(wg1[0]), 64'h1);

        // Both ports hold wreq for 4 cycles
        do_reset();
        m0_wreq = 1; m0_wdata = 32'hA; m0_wstrb = 4'h3;
        m1_wreq = 1; m1_wdata = 32'hB; m1_wstrb = 4'hC;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk($sformatf("alt[%0d] rr grants", k), 64'({wg1[0], wg0[0]}),
                64'((k % 2 == 1) ? 2'b10 : 2'b01));
            chk($sformatf("alt[%0d] rr t_wdata", k), 64'(twd[0]),
                64'((k % 2 == 1) ? 32'hB : 32'hA));
            chk($sformatf("alt[%0d] rr t_wstrb", k), 64'(tws[0]),
                64'((k % 2 == 1) ? 4'hC : 4'h3));
            chk($sformatf("alt[%0d] prio grants", k), 64'({wg1[1], wg0[1]}), 64'h1);
            chk($sformatf("alt[%0d] prio t_wdata", k), 64'(twd[1]), 64'hA);
            @(posedge clk);
            #1;
        end

        // Pipelined reads from alternating ports with response routing
        do_reset();
        m0_rreq = 1; m0_raddr = MTIME_BASE;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rd%0d c1 m0_rgrant", d), 64'(rg0[d]), 64'h1);
            chk($sformatf("rd%0d c1 t_raddr", d), 64'(tra[d]), 64'(MTIME_BASE));
        end
        @(posedge clk);
        #1;
        m0_rreq = 0; m1_rreq = 1; m1_raddr = MSIP_BASE;
        t_rresp = 1; t_rdata = 32'h55;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rd%0d c2 m1_rgrant", d), 64'(rg1[d]), 64'h1);
            chk($sformatf("rd%0d c2 t_raddr", d), 64'(tra[d]), 64'(MSIP_BASE));
            chk($sformatf("rd%0d c2 m0_rresp", d), 64'(rr0[d]), 64'h1);
            chk($sformatf("rd%0d c2 m0_rdata", d), 64'(rd0[d]), 64'h55);
            chk($sformatf("rd%0d c2 m1_rresp", d), 64'(rr1[d]), 64'h0);
            chk($sformatf("rd%0d c2 m1_rdata", d), 64'(rd1[d]), 64'h0);
        end
        @(posedge clk);
        #1;
        m1_rreq = 0; t_rresp = 1; t_rdata = 32'h0001_0000;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rd%0d c3 m1_rresp", d), 64'(rr1[d]), 64'h1);
            chk($sformatf("rd%0d c3 m1_rdata", d), 64'(rd1[d]), 64'h0001_0000);
            chk($sformatf("rd%0d c3 m0_rresp", d), 64'(rr0[d]), 64'h0);
            chk($sformatf("rd%0d c3 m0_rdata", d), 64'(rd0[d]), 64'h0);
        end
        @(posedge clk);
        #1;
        t_rresp = 1; t_rdata = 32'hDEAD_BEEF;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rd%0d spurious rresp", d), 64'({rr1[d], rr0[d]}), 64'h0);
            chk($sformatf("rd%0d spurious rdata", d), 64'({rd1[d], rd0[d]}), 64'h0);
        end

        // Simultaneous m0 write and m1 read
        do_reset();
        m0_wreq = 1; m0_waddr = MTIMECMP_BASE; m0_wdata = 32'h1234;
        m1_rreq = 1; m1_raddr = MTIMECMP_BASE;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("wr+rd%0d grants", d), 64'({wg0[d], rg1[d]}), 64'h3);
            chk($sformatf("wr+rd%0d strobes", d), 64'({twr[d], trr[d]}), 64'h3);
        end

        // Reset between a read grant and its response
        do_reset();
        m0_rreq = 1; m0_wreq = 1; m0_raddr = MTIME_BASE;
        #3;
        chk("rst rd grant", 64'({rg0[0], wg0[0]}), 64'h3);
        @(posedge clk);
        #1;
        m0_rreq = 0; m0_wreq = 0;
        resetb = 1'b0;
        t_rresp = 1; t_rdata = 32'h77;
        #3;
        for (int d = 0; d < 2; d++)
            chk($sformatf("rst%0d in-reset rresp", d), 64'({rr1[d], rr0[d]}), 64'h0);
        @(posedge clk);
        #1;
        resetb = 1'b1;
        model_reset();
        #3;
        for (int d = 0; d < 2; d++)
            chk($sformatf("rst%0d late rresp", d), 64'({rr1[d], rr0[d]}), 64'h0);
        @(posedge clk);
        #1;
        t_rresp = 0;
        m0_wreq = 1; m1_wreq = 1; m0_rreq = 1; m1_rreq = 1;
        #3;
        chk("rst rr wgrant tie", 64'({wg1[0], wg0[0]}), 64'h1);
        chk("rst rr rgrant tie", 64'({rg1[0], rg0[0]}), 64'h1);

        // Random run against the model; the bench plays the timer
        do_reset();
        prev_rd = 1'b0;
        for (int i = 0; i < 400; i++) begin
            m0_wreq  = 1'($urandom_range(1));
            m1_wreq  = 1'($urandom_range(1));
            m0_rreq  = 1'($urandom_range(1));
            m1_rreq  = 1'($urandom_range(1));
            m0_waddr = $urandom; m1_waddr = $urandom;
            m0_raddr = $urandom; m1_raddr = $urandom;
            m0_wdata = $urandom; m1_wdata = $urandom;
            m0_wstrb = 4'($urandom); m1_wstrb = 4'($urandom);
            t_rresp  = prev_rd | ($urandom_range(7) == 0);
            t_rdata  = $urandom;
            prev_rd  = m0_rreq | m1_rreq;
            #3;
            model_check();
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
